// File: rtl/carrier_acq_pkg.sv
// Shared state codes and limits for the carrier-loop acquisition sequencer.
package carrier_acq_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_CLEAR = 3'd1;
   localparam state_t ST_ACQ   = 3'd2;
   localparam state_t ST_DWELL = 3'd3;
   localparam state_t ST_TRACK = 3'd4;

   localparam logic [7:0] REACQ_MAX = 8'hff;

endpackage

// File: rtl/carrier_acq_if.sv
// Control/status bundle between the acquisition sequencer (slave) and the carrier loop side (master).
interface carrier_acq_if
   import carrier_acq_pkg::*;
#(
   parameter int unsigned EXP_W   = 5,
   parameter int unsigned TMR_W   = 24,
   parameter int unsigned DWELL_W = 16
);
   logic               enable;
   logic               loopEn;
   logic               carrierLock;
   logic               sweepAllowed;
   logic [EXP_W-1:0]   acqLeadExp;
   logic [EXP_W-1:0]   acqLagExp;
   logic [EXP_W-1:0]   trkLeadExp;
   logic [EXP_W-1:0]   trkLagExp;
   logic [TMR_W-1:0]   acqTimeout;
   logic [DWELL_W-1:0] trkDwell;

   logic [EXP_W-1:0]   leadExp;
   logic [EXP_W-1:0]   lagExp;
   logic               sweepEnable;
   logic               clearAccum;
   state_t             state;
   logic               acqFail;
   logic [7:0]         reacqCount;

   modport slave (
      input  enable, loopEn, carrierLock, sweepAllowed,
      input  acqLeadExp, acqLagExp, trkLeadExp, trkLagExp, acqTimeout, trkDwell,
      output leadExp, lagExp, sweepEnable, clearAccum, state, acqFail, reacqCount
   );

   modport master (
      output enable, loopEn, carrierLock, sweepAllowed,
      output acqLeadExp, acqLagExp, trkLeadExp, trkLagExp, acqTimeout, trkDwell,
      input  leadExp, lagExp, sweepEnable, clearAccum, state, acqFail, reacqCount
   );

endinterface

// File: rtl/strobe_counter.sv
// Saturating strobe counter with synchronous clear and an equality flag against a compare value.
module strobe_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_clr,
   input  logic         i_inc,
   input  logic [W-1:0] i_cmp,
   output logic [W-1:0] o_count,
   output logic         o_eq_c
);
   logic [W-1:0] r_count;

   // Holds at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {W{1'b1}})) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_count = r_count;
   assign o_eq_c  = (r_count == i_cmp);

endmodule

// File: rtl/carrier_acq_sequencer.sv
// Carrier-loop acquisition sequencer: IDLE -> CLEAR -> ACQ -> DWELL -> TRACK, driving loop
// gains, sweep and accumulator clear, and re-acquiring on lock loss or acquisition timeout.
module carrier_acq_sequencer
   import carrier_acq_pkg::*;
#(
   parameter int unsigned EXP_W         = 5,
   parameter int unsigned TMR_W         = 24,
   parameter int unsigned DWELL_W       = 16,
   parameter int unsigned CLEAR_STROBES = 4
) (
   input logic          clk,
   input logic          reset,
   carrier_acq_if.slave bus
);
   localparam int unsigned CLR_W = $clog2(CLEAR_STROBES + 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [EXP_W-1:0]   r_lead;
   logic [EXP_W-1:0]   r_lag;
   logic               r_sweep;
   logic               r_clear;
   logic               r_fail;
   logic [7:0]         r_reacq;

   logic [EXP_W-1:0]   w_lead_nxt;
   logic [EXP_W-1:0]   w_lag_nxt;
   logic               w_sweep_nxt;
   logic               w_clear_nxt;
   logic               w_fail_nxt;
   logic               w_reacq_inc;
   logic               w_load;
   logic               w_illegal;
   logic               w_strobe;

   logic               w_clr_done;
   logic               w_tmr_eq;
   logic               w_timeout;
   logic               w_dwell_eq;
   logic               w_dwell_hit;
   logic [CLR_W-1:0]   w_clr_cnt_unused;
   logic [TMR_W-1:0]   w_tmr_cnt_unused;
   logic [DWELL_W-1:0] w_dwell_cnt;

   assign w_illegal = (r_state > ST_TRACK);
   assign w_strobe  = bus.enable & bus.loopEn & ~w_illegal;

   // Each counter is held at zero outside its own state, so every entry starts from zero.
   strobe_counter #(.W(CLR_W)) u_clr_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_clr   (~bus.enable | (r_state != ST_CLEAR)),
      .i_inc   (w_strobe & (r_state == ST_CLEAR)),
      .i_cmp   (CLR_W'(CLEAR_STROBES - 1)),
      .o_count (w_clr_cnt_unused),
      .o_eq_c  (w_clr_done)
   );

   strobe_counter #(.W(TMR_W)) u_tmr_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_clr   (~bus.enable | (r_state != ST_ACQ)),
      .i_inc   (w_strobe & (r_state == ST_ACQ)),
      .i_cmp   (TMR_W'(bus.acqTimeout - 1'b1)),
      .o_count (w_tmr_cnt_unused),
      .o_eq_c  (w_tmr_eq)
   );

   strobe_counter #(.W(DWELL_W)) u_dwell_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_clr   (~bus.enable | (r_state != ST_DWELL)),
      .i_inc   (w_strobe & (r_state == ST_DWELL) & bus.carrierLock),
      .i_cmp   (DWELL_W'(bus.trkDwell - 1'b1)),
      .o_count (w_dwell_cnt),
      .o_eq_c  (w_dwell_eq)
   );

   assign w_timeout = w_tmr_eq & (bus.acqTimeout != '0);
   // Dwell is met when this locked strobe brings the count up to trkDwell (or trkDwell shrank below it).
   assign w_dwell_hit = w_dwell_eq | (w_dwell_cnt >= bus.trkDwell);

   // Next state and the output values that go with it.
   always_comb begin
      w_state_nxt = r_state;
      w_fail_nxt  = 1'b0;
      w_reacq_inc = 1'b0;
      w_load      = 1'b0;

      if (!bus.enable || w_illegal) begin
         w_state_nxt = ST_IDLE;
         w_load      = 1'b1;
      end else if (bus.loopEn) begin
         w_load = 1'b1;
         case (r_state)
            ST_IDLE:  w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (w_clr_done) w_state_nxt = ST_ACQ;
            ST_ACQ: begin
               if (bus.carrierLock) begin
                  w_state_nxt = ST_DWELL;
               end else if (w_timeout) begin
                  w_state_nxt = ST_CLEAR;
                  w_fail_nxt  = 1'b1;
                  w_reacq_inc = 1'b1;
               end
            end
            ST_DWELL: begin
               if (!bus.carrierLock) begin
                  w_state_nxt = ST_ACQ;
               end else if (w_dwell_hit) begin
                  w_state_nxt = ST_TRACK;
               end
            end
            ST_TRACK: begin
               if (!bus.carrierLock) begin
                  w_state_nxt = ST_CLEAR;
                  w_reacq_inc = 1'b1;
               end
            end
            default:  w_state_nxt = ST_IDLE;
         endcase
      end

      w_lead_nxt  = (w_state_nxt == ST_TRACK) ? bus.trkLeadExp : bus.acqLeadExp;
      w_lag_nxt   = (w_state_nxt == ST_TRACK) ? bus.trkLagExp  : bus.acqLagExp;
      w_sweep_nxt = (w_state_nxt == ST_ACQ) & bus.sweepAllowed;
      w_clear_nxt = (w_state_nxt == ST_IDLE) | (w_state_nxt == ST_CLEAR);
   end

   // State and registered outputs; config-derived outputs only move on strobes or forced IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_lead  <= '0;
         r_lag   <= '0;
         r_sweep <= 1'b0;
         r_clear <= 1'b1;
         r_fail  <= 1'b0;
         r_reacq <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_fail  <= w_fail_nxt;
         if (w_load) begin
            r_lead  <= w_lead_nxt;
            r_lag   <= w_lag_nxt;
            r_sweep <= w_sweep_nxt;
            r_clear <= w_clear_nxt;
         end
         if (w_reacq_inc && (r_reacq != REACQ_MAX)) begin
            r_reacq <= r_reacq + 8'd1;
         end
      end
   end

   assign bus.leadExp     = r_lead;
   assign bus.lagExp      = r_lag;
   assign bus.sweepEnable = r_sweep;
   assign bus.clearAccum  = r_clear;
   assign bus.state       = r_state;
   assign bus.acqFail     = r_fail;
   assign bus.reacqCount  = r_reacq;

endmodule

// File: tb/tb_carrier_acq_sequencer.sv
// Randomized scoreboard bench for carrier_acq_sequencer against a strobe-level reference model.
module tb_carrier_acq_sequencer;

   localparam int EXP_W   = 5;
   localparam int TMR_W   = 10;
   localparam int DWELL_W = 16;
   localparam int NCLR    = 4;
   localparam int TMAX    = (1 << TMR_W) - 1;
   localparam int DMAX    = (1 << DWELL_W) - 1;

   typedef struct packed {
      logic [EXP_W-1:0] lead;
      logic [EXP_W-1:0] lag;
      logic             sweep;
      logic             clr;
      logic [2:0]       st;
      logic             fail;
      logic [7:0]       reacq;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   carrier_acq_if #(.EXP_W(EXP_W), .TMR_W(TMR_W), .DWELL_W(DWELL_W)) bus ();

   carrier_acq_sequencer #(
      .EXP_W(EXP_W), .TMR_W(TMR_W), .DWELL_W(DWELL_W), .CLEAR_STROBES(NCLR)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [TMR_W-1:0]   cfg_timeout;
   logic [DWELL_W-1:0] cfg_dwell;
   logic [EXP_W-1:0]   cfg_acq_lead, cfg_acq_lag, cfg_trk_lead, cfg_trk_lag;

   // Reference model: state name as an int, counters as plain integers.
   int   m_st, m_ccnt, m_tmr, m_dw, m_reacq;
   exp_t m_out;

   function automatic void chk(string name, int act, int expv);
      n_cmp++;
      if (act != expv) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, expv);
      end
   endfunction

   task automatic model_step();
      exp_t e;
      e = m_out;
      e.fail = 1'b0;
      if (reset) begin
         m_st = 0; m_ccnt = 0; m_tmr = 0; m_dw = 0; m_reacq = 0;
         e = '{lead: '0, lag: '0, sweep: 1'b0, clr: 1'b1, st: 3'd0, fail: 1'b0, reacq: 8'd0};
      end else if (!bus.enable) begin
         m_st = 0; m_ccnt = 0; m_tmr = 0; m_dw = 0;
         e.st = 3'd0; e.clr = 1'b1; e.sweep = 1'b0;
         e.lead = bus.acqLeadExp; e.lag = bus.acqLagExp;
      end else if (bus.loopEn) begin
         case (m_st)
            0: begin m_st = 1; m_ccnt = 0; end
            1: begin
               if (m_ccnt + 1 >= NCLR) begin m_st = 2; m_tmr = 0; end
               else m_ccnt++;
            end
            2: begin
               if (bus.carrierLock) begin
                  m_st = 3; m_dw = 0;
               end else if (bus.acqTimeout != 0 && m_tmr == int'(bus.acqTimeout) - 1) begin
                  e.fail = 1'b1;
                  if (m_reacq < 255) m_reacq++;
                  m_st = 1; m_ccnt = 0;
               end else begin
                  m_tmr = (m_tmr < TMAX) ? m_tmr + 1 : TMAX;
               end
            end
            3: begin
               if (!bus.carrierLock) begin
                  m_st = 2; m_tmr = 0;
               end else begin
                  if (m_dw + 1 >= int'(bus.trkDwell)) m_st = 4;
                  m_dw = (m_dw < DMAX) ? m_dw + 1 : DMAX;
               end
            end
            default: begin
               if (!bus.carrierLock) begin
                  m_st = 1; m_ccnt = 0;
                  if (m_reacq < 255) m_reacq++;
               end
            end
         endcase
         e.st    = 3'(m_st);
         e.lead  = (m_st == 4) ? bus.trkLeadExp : bus.acqLeadExp;
         e.lag   = (m_st == 4) ? bus.trkLagExp  : bus.acqLagExp;
         e.sweep = (m_st == 2) && bus.sweepAllowed;
         e.clr   = (m_st <= 1);
      end
      e.reacq = 8'(m_reacq);
      m_out = e;
      q.push_back(e);
   endtask

   // Apply one clock of stimulus between edges and queue the expected post-edge outputs.
   task automatic drive_cycle(input bit rst, input bit en, input bit le, input bit lk, input bit sa);
      @(negedge clk);
      #1;
      reset            = rst;
      bus.enable       = en;
      bus.loopEn       = le;
      bus.carrierLock  = lk;
      bus.sweepAllowed = sa;
      bus.acqTimeout   = cfg_timeout;
      bus.trkDwell     = cfg_dwell;
      bus.acqLeadExp   = cfg_acq_lead;
      bus.acqLagExp    = cfg_acq_lag;
      bus.trkLeadExp   = cfg_trk_lead;
      bus.trkLagExp    = cfg_trk_lag;
      model_step();
   endtask

   task automatic settle();
      @(posedge clk);
      #3;
   endtask

   task automatic new_gains();
      cfg_acq_lead = EXP_W'($urandom);
      cfg_acq_lag  = EXP_W'($urandom);
      cfg_trk_lead = EXP_W'($urandom);
      cfg_trk_lag  = EXP_W'($urandom);
   endtask

   // Monitor: every clock the DUT presents a fresh output set; pop and compare.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("state",       int'(bus.state),       int'(e.st));
            chk("leadExp",     int'(bus.leadExp),     int'(e.lead));
            chk("lagExp",      int'(bus.lagExp),      int'(e.lag));
            chk("sweepEnable", int'(bus.sweepEnable), int'(e.sweep));
            chk("clearAccum",  int'(bus.clearAccum),  int'(e.clr));
            chk("acqFail",     int'(bus.acqFail),     int'(e.fail));
            chk("reacqCount",  int'(bus.reacqCount),  int'(e.reacq));
         end
      end
   end

   initial begin
      bit lk;
      reset = 1'b1;
      bus.enable = 1'b0; bus.loopEn = 1'b0; bus.carrierLock = 1'b0; bus.sweepAllowed = 1'b0;
      bus.acqLeadExp = '0; bus.acqLagExp = '0; bus.trkLeadExp = '0; bus.trkLagExp = '0;
      bus.acqTimeout = '0; bus.trkDwell = '0;
      cfg_timeout = TMR_W'(100); cfg_dwell = DWELL_W'(50);
      new_gains();
      m_st = 0; m_ccnt = 0; m_tmr = 0; m_dw = 0; m_reacq = 0;
      m_out = '0;

      repeat (3) drive_cycle(1, 0, 0, 0, 0);

      // Clear run-in then two 100-strobe acquisition timeouts.
      repeat (230) drive_cycle(0, 1, 1, 0, 1'($urandom_range(0, 1)));
      settle();
      chk("reacq_after_two_timeouts", int'(bus.reacqCount), 2);
      chk("acq_after_timeouts",       int'(bus.state),      2);

      // Lock held past a 50-strobe dwell, then lock dropouts at assorted points.
      cfg_timeout = '0;
      repeat (60) drive_cycle(0, 1, 1, 1, 1'($urandom_range(0, 1)));
      settle();
      chk("track_after_dwell", int'(bus.state),   4);
      chk("track_lead_gain",   int'(bus.leadExp), int'(cfg_trk_lead));
      chk("track_lag_gain",    int'(bus.lagExp),  int'(cfg_trk_lag));
      for (int k = 0; k < 10; k++) begin
         int hold;
         hold = (k == 0) ? 30 : int'($urandom_range(20, 70));
         repeat (hold) drive_cycle(0, 1, 1, 1, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(1, 6)) drive_cycle(0, 1, 1, 0, 1'($urandom_range(0, 1)));
      end

      // Fast lock/drop cycling drives reacqCount into saturation.
      cfg_dwell = '0;
      for (int k = 0; k < 300; k++) begin
         repeat (6) drive_cycle(0, 1, 1, 1, 1'($urandom_range(0, 1)));
         drive_cycle(0, 1, 1, 0, 1'($urandom_range(0, 1)));
      end
      settle();
      chk("reacq_saturated", int'(bus.reacqCount), 255);

      // One-strobe timeout racing lock, then an unbounded ACQ past timer saturation.
      cfg_timeout = TMR_W'(1); cfg_dwell = DWELL_W'(2);
      repeat (200) drive_cycle(0, 1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cfg_timeout = '0;
      repeat (TMAX + 30) drive_cycle(0, 1, 1, 0, 1);
      settle();
      chk("acq_held_no_timeout", int'(bus.state), 2);

      // enable low mid-DWELL without a strobe, then reset asserted in TRACK.
      cfg_dwell = DWELL_W'(1000);
      repeat (5) drive_cycle(0, 1, 1, 1, 0);
      settle();
      chk("in_dwell", int'(bus.state), 3);
      drive_cycle(0, 0, 0, 1, 0);
      settle();
      chk("idle_on_disable", int'(bus.state), 0);
      cfg_dwell = DWELL_W'(1);
      repeat (12) drive_cycle(0, 1, 1, 1, 1);
      settle();
      chk("track_before_reset", int'(bus.state), 4);
      drive_cycle(1, 1, 1, 1, 1);
      settle();
      chk("reset_state",  int'(bus.state),      0);
      chk("reset_clear",  int'(bus.clearAccum), 1);
      chk("reset_lead",   int'(bus.leadExp),    0);
      chk("reset_reacq",  int'(bus.reacqCount), 0);

      // Fully random traffic with occasional reset, disable and config changes.
      lk = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 99) < 10) lk = ~lk;
         if ($urandom_range(0, 99) < 5) begin
            cfg_timeout = TMR_W'($urandom_range(0, 40));
            cfg_dwell   = DWELL_W'($urandom_range(0, 20));
            new_gains();
         end
         drive_cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 96),
                     ($urandom_range(0, 99) < 60), lk, 1'($urandom_range(0, 1)));
      end
      settle();
      chk("queue_drained", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
